// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the Moore "101" detector.
// Accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit
// per clock on x. Words can follow each other with no idle gap. x is held at
// 0 while idle so the detector never sees a stray 1.
// Optional even-parity trailer bit: define BIT_SERIALIZER_PARITY_EN.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active-low
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             done,
    output logic             busy
);

    localparam int            CW           = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST_IDX = CW'(WIDTH - 2);

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;   // bits still waiting to go out
    logic [CW-1:0]    cnt_q, cnt_d;       // index of the bit currently on x
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             done_q, done_d;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             accept;

    // Bit that leaves first from a freshly loaded word.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Remove the head bit so the next one moves into the head position.
    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign accept = din_valid && din_ready;

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            done_q    <= done_d;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state logic, the ready decode and the next registered serial outputs.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        done_d    = 1'b0;
        din_ready = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        parity_d  = parity_q;
`endif

        // Ready whenever the bit now on x is the last one of its frame, so
        // the next word's first bit follows with no gap.
        case (state_q)
            IDLE:   din_ready = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            SHIFT:  din_ready = 1'b0;
            PARITY: din_ready = 1'b1;
`else
            SHIFT:  din_ready = (cnt_q == LAST_IDX);
`endif
            default: din_ready = 1'b0;
        endcase

        if (accept) begin
            // Load a new word; its head bit is registered onto x right away.
            state_d   = SHIFT;
            shreg_d   = drop_head(din);
            cnt_d     = '0;
            x_d       = head_bit(din);
            x_valid_d = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_d  = ^din;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q != LAST_IDX) begin
                        x_d       = head_bit(shreg_q);
                        x_valid_d = 1'b1;
                        shreg_d   = drop_head(shreg_q);
                        cnt_d     = cnt_q + CW'(1);
`ifdef BIT_SERIALIZER_PARITY_EN
                        done_d    = 1'b0;
`else
                        done_d    = (cnt_q == PRE_LAST_IDX);
`endif
                    end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                        // Last data bit on x now; the parity bit closes the frame.
                        state_d   = PARITY;
                        x_d       = parity_q;
                        x_valid_d = 1'b1;
                        done_d    = 1'b1;
`else
                        state_d   = IDLE;
                        cnt_d     = '0;
`endif
                    end
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                PARITY: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed bench for bit_serializer with a per-instance
// scoreboard of expected {bit, done} pairs. Instance A sends MSB first,
// instance B sends LSB first. Each expected frame is queued when a word is
// accepted and popped one entry per x_valid cycle.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
    localparam int FRAME     = 9;
`else
    localparam bit PARITY_EN = 1'b0;
    localparam int FRAME     = 8;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din_a, din_b;
    logic       din_valid_a, din_valid_b;
    logic       din_ready_a, din_ready_b;
    logic       x_a, x_b, xv_a, xv_b, done_a, done_b, busy_a, busy_b;

    logic [1:0] qa[$];   // {expected bit, expected done}
    logic [1:0] qb[$];
    bit         acc_a, acc_b;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         n;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .din(din_a), .din_valid(din_valid_a),
        .din_ready(din_ready_a), .x(x_a), .x_valid(xv_a), .done(done_a), .busy(busy_a)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .din(din_b), .din_valid(din_valid_b),
        .din_ready(din_ready_b), .x(x_b), .x_valid(xv_b), .done(done_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Queue the expected serial frame for a word accepted by instance `which`.
    task automatic push(input int which, input logic [7:0] w);
        logic [1:0] e;
        int         idx;
        for (int i = 0; i < 8; i++) begin
            idx = (which == 0) ? 7 - i : i;
            e   = {w[idx], (i == 7) && !PARITY_EN};
            if (which == 0) qa.push_back(e); else qb.push_back(e);
        end
        if (PARITY_EN) begin
            e = {^w, 1'b1};
            if (which == 0) qa.push_back(e); else qb.push_back(e);
        end
    endtask

    // Compare one instance's outputs against the head of its scoreboard.
    task automatic monitor(input int which);
        logic [1:0] e;
        logic       xo, xvo, dno, rdo, byo;
        int         qsz;
        string      p;
        if (which == 0) begin
            xo = x_a; xvo = xv_a; dno = done_a; rdo = din_ready_a; byo = busy_a;
            qsz = qa.size(); p = "A";
        end else begin
            xo = x_b; xvo = xv_b; dno = done_b; rdo = din_ready_b; byo = busy_b;
            qsz = qb.size(); p = "B";
        end
        check({p, ".x_valid"}, 32'(xvo), 32'(qsz > 0));
        if (qsz > 0) begin
            if (which == 0) e = qa.pop_front(); else e = qb.pop_front();
            check({p, ".x"}, 32'(xo), 32'(e[1]));
            check({p, ".done"}, 32'(dno), 32'(e[0]));
            check({p, ".din_ready"}, 32'(rdo), 32'(e[0]));
            check({p, ".busy"}, 32'(byo), 32'd1);
        end else begin
            check({p, ".x_idle"}, 32'(xo), 32'd0);
            check({p, ".done_idle"}, 32'(dno), 32'd0);
            check({p, ".ready_idle"}, 32'(rdo), 32'd1);
            check({p, ".busy_idle"}, 32'(byo), 32'd0);
        end
    endtask

    // One clock: note handshakes before the edge, check outputs 1 time unit after it.
    task automatic cycle();
        bit la, lb;
        la = reset && din_valid_a && din_ready_a;
        lb = reset && din_valid_b && din_ready_b;
        if (la) begin push(0, din_a); $display("accept A din=%02h", din_a); end
        if (lb) begin push(1, din_b); $display("accept B din=%02h", din_b); end
        @(posedge clk);
        #1;
        acc_a = la;
        acc_b = lb;
        monitor(0);
        monitor(1);
    endtask

    initial begin
        reset = 1'b0;
        din_a = 8'h00; din_b = 8'h00;
        din_valid_a = 1'b0; din_valid_b = 1'b0;

        // Reset held, then released with no traffic.
        repeat (2) cycle();
        reset = 1'b1;
        repeat (5) cycle();

        // Single word, MSB first.
        din_a = 8'hA0; din_valid_a = 1'b1;
        cycle();
        check("accept_A0", 32'(acc_a), 32'd1);
        din_valid_a = 1'b0;
        repeat (FRAME + 2) cycle();

        // Back-to-back words with valid held high.
        din_a = 8'hA5; din_valid_a = 1'b1;
        cycle();
        check("accept_A5", 32'(acc_a), 32'd1);
        din_a = 8'h3C;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!acc_a && n < 20);
        check("b2b_accept_cycle", 32'(n), 32'(FRAME));
        din_valid_a = 1'b0;
        repeat (FRAME + 2) cycle();

        // LSB-first instance.
        din_b = 8'h01; din_valid_b = 1'b1;
        cycle();
        check("accept_B01", 32'(acc_b), 32'd1);
        din_valid_b = 1'b0;
        repeat (FRAME + 2) cycle();

        // Reset in the middle of a word.
        din_a = 8'hFF; din_valid_a = 1'b1;
        cycle();
        din_valid_a = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;
        #1;
        check("rst_mid.x", 32'(x_a), 32'd0);
        check("rst_mid.x_valid", 32'(xv_a), 32'd0);
        check("rst_mid.busy", 32'(busy_a), 32'd0);
        check("rst_mid.done", 32'(done_a), 32'd0);
        check("rst_mid.din_ready", 32'(din_ready_a), 32'd1);
        qa.delete();
        qb.delete();
        repeat (2) cycle();
        reset = 1'b1;
        din_a = 8'h80; din_valid_a = 1'b1;
        cycle();
        check("accept_80", 32'(acc_a), 32'd1);
        din_valid_a = 1'b0;
        repeat (FRAME + 2) cycle();

        // Word whose parity bit is 1 when the trailer is built in.
        din_a = 8'h07; din_valid_a = 1'b1;
        cycle();
        check("accept_07", 32'(acc_a), 32'd1);
        din_valid_a = 1'b0;
        repeat (FRAME + 2) cycle();

        // Random back-to-back stream on both instances.
        din_a = 8'($urandom); din_b = 8'($urandom);
        din_valid_a = 1'b1; din_valid_b = 1'b1;
        for (int k = 0; k < 60; k++) begin
            cycle();
            if (acc_a) din_a = 8'($urandom);
            if (acc_b) din_b = 8'($urandom);
        end
        din_valid_a = 1'b0; din_valid_b = 1'b0;
        repeat (FRAME + 3) cycle();
        check("A.queue_drained", 32'(qa.size()), 32'd0);
        check("B.queue_drained", 32'(qb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stage directly upstream of the Moore "101" sequence detector.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `x`, the detector's serial input.
- Supports gap-free back-to-back words so a detected pattern can straddle a word boundary.
- Drives `x` to 0 when idle so the detector sees no spurious 1s.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din is presented; upstream holds din stable until accepted.
- din_ready  output  1  block can accept a word this cycle.
- x  output  1  serial bit; feeds the detector's `x` input.
- x_valid  output  1  `x` carries a data or parity bit this cycle.
- done  output  1  one-cycle pulse coincident with the final bit of a word.
- busy  output  1  a word is in flight (state != IDLE).

Behaviour:
- Reset (reset=0, asynchronous, effective immediately):
  - state=IDLE, shift register=0, bit count=0.
  - x=0, x_valid=0, done=0, busy=0, din_ready=1.
- States:
  - IDLE and SHIFT.
  - PARITY exists only when the optional feature is compiled in.
- Acceptance occurs on a rising edge where din_valid=1 and din_ready=1:
  - The shift register loads din and the bit count is cleared.
  - State goes to SHIFT.
- Latency:
  - The first bit appears on `x` (registered) in the cycle after acceptance.
  - Each bit is held for exactly one clock.
- SHIFT:
  - Each cycle outputs the next bit in MSB_FIRST order and increments the count.
  - Bit index WIDTH-1 is the last data bit.
- din_ready (combinational from state and count):
  - 1 in IDLE.
  - 1 in SHIFT on the last data bit when parity is disabled.
  - 1 in PARITY.
  - 0 otherwise.
- Back-to-back: if a word is accepted on the final-bit cycle, its first bit follows with no idle gap. x_valid stays 1 continuously.
- No word accepted on the final-bit cycle: the next state is IDLE, and x=0, x_valid=0 from the following cycle.
- din_valid while din_ready=0: ignored. No state change and no loss; upstream must hold the word.
- done:
  - Registered, high for exactly one cycle aligned with the final bit on `x`.
  - The final bit is the last data bit, or the parity bit when that feature is enabled.
- busy=1 whenever state != IDLE.
- Reset mid-word: the partial word is discarded. Outputs take reset values asynchronously, and the next accepted word starts from bit 0.
- The count register is $clog2(WIDTH+1) bits wide and never wraps past WIDTH-1.

Optional Feature:
- Macro: BIT_SERIALIZER_PARITY_EN.
- When defined:
  - After the last data bit, state goes to PARITY for one cycle.
  - x = even-parity bit (XOR of all WIDTH data bits), with x_valid=1 and done=1 on that cycle.
  - din_ready=1 in PARITY; the last data bit is not a final bit.
  - Frame length is WIDTH+1 cycles.
- When undefined:
  - The PARITY state and logic are absent.
  - Frame length is WIDTH cycles, and done plus early din_ready occur on the last data bit.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, then release with din_valid=0 for 5 cycles. Required: x=0, x_valid=0, done=0, busy=0, din_ready=1 throughout.
2. MSB_FIRST=1, din=8'hA0 accepted at cycle T. Required:
   - x=1,0,1,0,0,0,0,0 on cycles T+1..T+8; done=1 only at T+8.
   - x_valid=0 and x=0 at T+9.
   - The downstream detector flags "101" after the third bit.
3. Back-to-back: din=8'hA5 then 8'h3C, din_valid held high. Required:
   - Second word accepted on the cycle din_ready rises (final-bit cycle of word 1).
   - 16 contiguous x_valid cycles carrying 1010_0101_0011_1100; done pulses at bit 8 and bit 16.
4. MSB_FIRST=0, din=8'h01. Required: x=1 on the first bit cycle, then seven 0s; done on the 8th.
5. Reset mid-word: din=8'hFF, then reset=0 after 3 bits have been emitted. Required:
   - x=0, x_valid=0, busy=0 immediately.
   - After release, word 8'h80 is serialized fully from its MSB (1 followed by seven 0s).
6. With BIT_SERIALIZER_PARITY_EN, din=8'h07 (MSB_FIRST=1). Required:
   - x=0,0,0,0,0,1,1,1 then parity bit 1 over 9 cycles.
   - done only on the 9th cycle; din_ready=0 during the 8 data bits.
